mdu_seq: RTL and testbench

- Parametrised sequential multiply/divide unit for the multicycle MIPS datapath.
- Replaces single-cycle combinational mult/div with a radix-2 iterative engine: one partial product or one quotient bit per cycle.
- Owns the HI/LO result registers and handshakes with the control FSM via Start/Busy/Done.
- Sits beside the ALU; the controller stalls on Busy.

---
 rtl/mdu_seq.sv | 191 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: radix-2 iterative multiply/divide unit with HI/LO registers.
// Optional MDU_FAST_MUL_EN: single-cycle multiply path.
module mdu_seq #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DATA_SIZE-1:0] SrcA,
  input  logic [DATA_SIZE-1:0] SrcB,
  input  logic                 Abort,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Unvalid,
  output logic [DATA_SIZE-1:0] Hi,
  output logic [DATA_SIZE-1:0] Lo
);

  localparam int W = DATA_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                negp_q, negp_d;
  logic                negr_q, negr_d;
  logic                dz_q, dz_d;
  logic [W-1:0]        hi_q, hi_d;
  logic [W-1:0]        lo_q, lo_d;
  logic                done_q, done_d;
  logic                unv_q, unv_d;

  logic                sgn;
  logic [W-1:0]        abs_a, abs_b;
  logic [W:0]          mul_sum;
  logic [W:0]          div_sh;
  logic [W:0]          div_diff;
  logic                q_bit;
  logic [W-1:0]        div_rem;
  logic [2*W-1:0]      prod;
  logic [2*W-1:0]      prod_s;
  logic [W-1:0]        quo_s;
  logic [W-1:0]        rem_s;

  // Operand conditioning and one radix-2 iteration step
  always_comb begin
    sgn      = ~Op[0];
    abs_a    = (sgn && SrcA[W-1]) ? (~SrcA + 1'b1) : SrcA;
    abs_b    = (sgn && SrcB[W-1]) ? (~SrcB + 1'b1) : SrcB;
    mul_sum  = {1'b0, acc_q[2*W-1:W]}
             + {1'b0, (b_q[0] ? a_q : {W{1'b0}})};
    div_sh   = {acc_q[2*W-1:W], a_q[W-1]};
    div_diff = div_sh - {1'b0, b_q};
    q_bit    = ~div_diff[W];
    div_rem  = q_bit ? div_diff[W-1:0] : div_sh[W-1:0];
`ifdef MDU_FAST_MUL_EN
    prod     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`else
    prod     = acc_q;
`endif
    prod_s   = negp_q ? (~prod + 1'b1) : prod;
    quo_s    = negp_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_s    = negr_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unv_d   = unv_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d   = Op;
          a_d    = abs_a;
          b_d    = abs_b;
          negp_d = sgn & (SrcA[W-1] ^ SrcB[W-1]);
          negr_d = sgn & SrcA[W-1];
          acc_d  = '0;
          cnt_d  = '0;
          dz_d   = Op[1] & (SrcB == '0);
          if (Op[1] && (SrcB == '0)) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
`ifdef MDU_FAST_MUL_EN
          if (!Op[1]) begin
            state_d = FIX;
          end
`endif
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            acc_d = {div_rem, acc_q[W-2:0], q_bit};
            a_d   = {a_q[W-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
            b_d   = {1'b0, b_q[W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_SIZE'(W - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!Abort) begin
          done_d = 1'b1;
          unv_d  = dz_q;
          if (dz_q) begin
            hi_d = '0;
            lo_d = '0;
          end else if (op_q[1]) begin
            hi_d = rem_s;
            lo_d = quo_s;
          end else begin
            hi_d = prod_s[2*W-1:W];
            lo_d = prod_s[W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      unv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      unv_q   <= unv_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Unvalid = unv_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed checks of mdu_seq results, latency and control.
// Expected values are hand-computed constants.
module tb_mdu_seq;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic        Unvalid;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  mdu_seq #(.DATA_SIZE(32), .CNT_SIZE(6)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .SrcA(SrcA), .SrcB(SrcB), .Abort(Abort),
    .Busy(Busy), .Done(Done), .Unvalid(Unvalid),
    .Hi(Hi), .Lo(Lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    Op    = 2'(($urandom));
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLK);
      #1;
      if (Done) begin
        lat = i;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
    end
  endtask

  int lat;
  bit bok;
  int ndone;
  int first;

  initial begin
    RST = 1'b0; Start = 1'b0; Abort = 1'b0;
    Op = 2'b00; SrcA = '0; SrcB = '0;
    #12;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_unv", 64'(Unvalid), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    chk("multu_lat", 64'(lat), 64'(MUL_LAT));
    chk("multu_busy", 64'(bok), 64'd1);
    chk("multu_busy_at_done", 64'(Busy), 64'd0);
    chk("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(Lo), 64'h0000_0001);

    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bok);
    chk("mult_lat", 64'(lat), 64'(MUL_LAT));
    chk("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFF_FFF1);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bok);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_lo", 64'(Lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(Hi), 64'hFFFF_FFFF);
    issue(2'b11, 32'd7, 32'd2);
    chk("b2b_done_pulse", 64'(Done), 64'd0);
    chk("b2b_busy", 64'(Busy), 64'd1);
    wait_done(lat, bok);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_lo", 64'(Lo), 64'd3);
    chk("b2b_hi", 64'(Hi), 64'd1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    chk("ovf_lo", 64'(Lo), 64'h8000_0000);
    chk("ovf_hi", 64'(Hi), 64'd0);
    chk("ovf_unv", 64'(Unvalid), 64'd0);
    issue(2'b11, 32'd5, 32'd0);
    wait_done(lat, bok);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_hi", 64'(Hi), 64'd0);
    chk("dz_lo", 64'(Lo), 64'd0);
    chk("dz_unv", 64'(Unvalid), 64'd1);
    @(posedge CLK);
    #1;
    chk("dz_unv_hold", 64'(Unvalid), 64'd1);
    chk("dz_done_low", 64'(Done), 64'd0);

    issue(2'b11, 32'd100, 32'd7);
    ndone = 0;
    first = -1;
    for (int i = 1; i <= 45; i++) begin
      @(posedge CLK);
      #1;
      if (Done) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (i == 4) begin
        Start = 1'b1; Op = 2'b01; SrcA = 32'd3; SrcB = 32'd3;
      end
      if (i == 5) Start = 1'b0;
    end
    chk("ign_first", 64'(first), 64'd33);
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lo", 64'(Lo), 64'd14);
    chk("ign_hi", 64'(Hi), 64'd2);
    chk("ign_unv", 64'(Unvalid), 64'd0);
    chk("ign_idle", 64'(Busy), 64'd0);

    issue(2'b11, 32'd5, 32'd2);
    wait_done(lat, bok);
    chk("pre_hi", 64'(Hi), 64'd1);
    chk("pre_lo", 64'(Lo), 64'd2);
    issue(2'b00, 32'd7, 32'd9);
    repeat (9) @(posedge CLK);
    #1;
    Abort = 1'b1;
    @(posedge CLK);
    #1;
    Abort = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (Done) ndone++;
    end
    chk("abort_ndone", 64'(ndone), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd1);
    chk("abort_lo", 64'(Lo), 64'd2);

    issue(2'b01, 32'd1234, 32'd5678);
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("arst_busy", 64'(Busy), 64'd0);
    chk("arst_hi", 64'(Hi), 64'd0);
    chk("arst_lo", 64'(Lo), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    chk("post_hi", 64'(Hi), 64'd0);
    chk("post_lo", 64'(Lo), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
